// File: rtl/logic_unit_pkg.sv
// Op-code definitions shared by the logic unit pipeline and its per-bit gate cell.
package logic_unit_pkg;

  localparam int OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_AND    = 3'b000,
    OP_OR     = 3'b001,
    OP_NAND   = 3'b010,
    OP_NOR    = 3'b011,
    OP_XOR    = 3'b100,
    OP_XNOR   = 3'b101,
    OP_PASS_A = 3'b110,
    OP_NOT_A  = 3'b111
  } op_e;

endpackage

// File: rtl/gate_mux_cell.sv
// One-bit gate built as a 2:1 mux: b_i selects between two functions of a_i chosen by op_i.
module gate_mux_cell
  import logic_unit_pkg::*;
(
  input  logic            a_i,
  input  logic            b_i,
  input  logic [OP_W-1:0] op_i,
  output logic            y_o
);

  logic sel1_s;
  logic sel0_s;

  // Pick the two mux legs for the requested operation
  always_comb begin
    sel1_s = 1'b0;
    sel0_s = 1'b0;
    case (op_e'(op_i))
      OP_AND:    begin sel1_s = a_i;  sel0_s = 1'b0; end
      OP_OR:     begin sel1_s = 1'b1; sel0_s = a_i;  end
      OP_NAND:   begin sel1_s = ~a_i; sel0_s = 1'b1; end
      OP_NOR:    begin sel1_s = 1'b0; sel0_s = ~a_i; end
      OP_XOR:    begin sel1_s = ~a_i; sel0_s = a_i;  end
      OP_XNOR:   begin sel1_s = a_i;  sel0_s = ~a_i; end
      OP_PASS_A: begin sel1_s = a_i;  sel0_s = a_i;  end
      OP_NOT_A:  begin sel1_s = ~a_i; sel0_s = ~a_i; end
      default:   begin sel1_s = 1'b0; sel0_s = 1'b0; end
    endcase
  end

  assign y_o = b_i ? sel1_s : sel0_s;

endmodule

// File: rtl/logic_unit_pipe.sv
// Bitwise mux-gate logic unit with a 2-entry in-order result FIFO.
// Define LOGIC_UNIT_PIPE_STATS_EN to build the accepted-operation counter.
module logic_unit_pipe
  import logic_unit_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [OP_W-1:0]  in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_y,
  output logic             out_zero,
  output logic [CNT_W-1:0] op_count
);

  logic [WIDTH-1:0] res_s;
  logic             res_zero_s;
  logic             push_s;
  logic             pop_s;

  logic [1:0]       occ_q, occ_d;
  logic [WIDTH-1:0] y0_q, y0_d, y1_q, y1_d;
  logic             z0_q, z0_d, z1_q, z1_d;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    gate_mux_cell u_cell (
      .a_i  (in_a[i]),
      .b_i  (in_b[i]),
      .op_i (in_op),
      .y_o  (res_s[i])
    );
  end

  assign res_zero_s = (res_s == {WIDTH{1'b0}});
  assign in_ready   = (occ_q != 2'd2);
  assign out_valid  = (occ_q != 2'd0);
  assign push_s     = in_valid & in_ready;
  assign pop_s      = out_valid & out_ready;

  // Entry 0 is always the head; vacated entries are zeroed so idle outputs read 0
  assign out_y    = y0_q;
  assign out_zero = z0_q;

  // FIFO next state: shift on pop, append behind the head on push
  always_comb begin
    occ_d = occ_q;
    y0_d  = y0_q;
    z0_d  = z0_q;
    y1_d  = y1_q;
    z1_d  = z1_q;
    case (occ_q)
      2'd0: begin
        if (push_s) begin
          occ_d = 2'd1;
          y0_d  = res_s;
          z0_d  = res_zero_s;
        end else begin
          occ_d = 2'd0;
        end
      end
      2'd1: begin
        if (push_s && pop_s) begin
          y0_d = res_s;
          z0_d = res_zero_s;
        end else if (push_s) begin
          occ_d = 2'd2;
          y1_d  = res_s;
          z1_d  = res_zero_s;
        end else if (pop_s) begin
          occ_d = 2'd0;
          y0_d  = {WIDTH{1'b0}};
          z0_d  = 1'b0;
        end else begin
          occ_d = 2'd1;
        end
      end
      2'd2: begin
        if (pop_s) begin
          occ_d = 2'd1;
          y0_d  = y1_q;
          z0_d  = z1_q;
          y1_d  = {WIDTH{1'b0}};
          z1_d  = 1'b0;
        end else begin
          occ_d = 2'd2;
        end
      end
      default: begin
        occ_d = 2'd0;
        y0_d  = {WIDTH{1'b0}};
        z0_d  = 1'b0;
        y1_d  = {WIDTH{1'b0}};
        z1_d  = 1'b0;
      end
    endcase
  end

  // FIFO state registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      occ_q <= 2'd0;
      y0_q  <= {WIDTH{1'b0}};
      z0_q  <= 1'b0;
      y1_q  <= {WIDTH{1'b0}};
      z1_q  <= 1'b0;
    end else begin
      occ_q <= occ_d;
      y0_q  <= y0_d;
      z0_q  <= z0_d;
      y1_q  <= y1_d;
      z1_q  <= z1_d;
    end
  end

`ifdef LOGIC_UNIT_PIPE_STATS_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign cnt_d    = push_s ? (cnt_q + {{(CNT_W-1){1'b0}}, 1'b1}) : cnt_q;
  assign op_count = cnt_q;

  // Accepted-operation counter, wraps naturally
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  assign op_count = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Self-checking bench for logic_unit_pipe against a queue-based reference model.
module tb_logic_unit_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [7:0]  in_a, in_b;
  logic [2:0]  in_op;
  logic        out_ready;
  logic        in_ready, out_valid, out_zero;
  logic [7:0]  out_y;
  logic [15:0] op_count;
  logic        in_ready4, out_valid4, out_zero4;
  logic [7:0]  out_y4;
  logic [3:0]  op_count4;

  int n_assert = 0;
  int n_fail   = 0;

  logic [7:0]  q_y[$];
  int unsigned acc_cnt;
  int          pops;

  always #5 clk = ~clk;

  logic_unit_pipe #(.WIDTH(8), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .out_valid(out_valid),
    .out_ready(out_ready), .out_y(out_y), .out_zero(out_zero), .op_count(op_count)
  );

  logic_unit_pipe #(.WIDTH(8), .CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready4),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .out_valid(out_valid4),
    .out_ready(out_ready), .out_y(out_y4), .out_zero(out_zero4), .op_count(op_count4)
  );

  function automatic logic [7:0] ref_op(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
    case (op)
      3'd0:    return a & b;
      3'd1:    return a | b;
      3'd2:    return ~(a & b);
      3'd3:    return ~(a | b);
      3'd4:    return a ^ b;
      3'd5:    return ~(a ^ b);
      3'd6:    return a;
      default: return ~a;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: compare all outputs against the model, then advance the model across the edge.
  task automatic tick();
    logic        e_valid, e_ready, f_in, f_out, in_rst;
    logic [7:0]  e_y;
    logic [15:0] e_cnt;
    @(negedge clk);
    e_valid = (q_y.size() != 0);
    e_y     = e_valid ? q_y[0] : 8'h00;
    e_ready = (q_y.size() < 2);
`ifdef LOGIC_UNIT_PIPE_STATS_EN
    e_cnt = acc_cnt[15:0];
`else
    e_cnt = 16'h0000;
`endif
    chk("out_valid", 64'(out_valid), 64'(e_valid));
    chk("out_y", 64'(out_y), 64'(e_y));
    chk("out_zero", 64'(out_zero), 64'(e_valid && (e_y == 8'h00)));
    chk("in_ready", 64'(in_ready), 64'(e_ready));
    chk("op_count", 64'(op_count), 64'(e_cnt));
    chk("op_count_w4", 64'(op_count4), 64'(e_cnt[3:0]));
    chk("out_y_w4", 64'(out_y4), 64'(e_y));
    f_in   = in_valid && e_ready;
    f_out  = e_valid && out_ready;
    in_rst = !rst_n;
    @(posedge clk);
    #1;
    if (in_rst) begin
      q_y.delete();
      acc_cnt = 0;
    end else begin
      if (f_out) begin
        void'(q_y.pop_front());
        pops++;
      end
      if (f_in) begin
        q_y.push_back(ref_op(in_a, in_b, in_op));
        acc_cnt++;
      end
    end
  endtask

  task automatic drive(input logic v, input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
    in_valid = v;
    in_a     = a;
    in_b     = b;
    in_op    = op;
  endtask

  initial begin
    acc_cnt = 0;
    pops    = 0;
    rst_n = 1'b0;
    out_ready = 1'b1;
    drive(1'b0, 8'h00, 8'h00, 3'd0);
    @(posedge clk);
    #1;
    tick();

    // Reset state
    rst_n = 1'b1;
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_ready", 64'(in_ready), 64'd1);

    // Directed functional vectors
    drive(1'b1, 8'hF0, 8'hCC, 3'd0); tick();
    chk("and_y", 64'(out_y), 64'h00C0);
    chk("and_zero", 64'(out_zero), 64'd0);
    drive(1'b1, 8'hF0, 8'hCC, 3'd4); tick();
    chk("xor_y", 64'(out_y), 64'h003C);
    drive(1'b1, 8'hF0, 8'hCC, 3'd3); tick();
    chk("nor_y", 64'(out_y), 64'h0003);
    drive(1'b1, 8'h0F, 8'hF0, 3'd0); tick();
    chk("and_zero_y", 64'(out_y), 64'h0000);
    chk("and_zero_flag", 64'(out_zero), 64'd1);
    drive(1'b0, 8'hAA, 8'h55, 3'd1); tick(); tick();
    chk("idle_valid", 64'(out_valid), 64'd0);

    // Backpressure: three offers with out_ready low
    out_ready = 1'b0;
    drive(1'b1, 8'h12, 8'h34, 3'd1); tick();
    drive(1'b1, 8'h56, 8'h78, 3'd2); tick();
    chk("full_ready", 64'(in_ready), 64'd0);
    drive(1'b1, 8'h9A, 8'hBC, 3'd5); tick(); tick();
    chk("hold_y", 64'(out_y), 64'(ref_op(8'h12, 8'h34, 3'd1)));
    out_ready = 1'b1;
    tick(); tick();
    drive(1'b0, 8'h00, 8'h00, 3'd0);
    tick(); tick();

    // Sustained stream of 100 random ops
    pops = 0;
    for (int i = 0; i < 100; i++) begin
      drive(1'b1, 8'($urandom), 8'($urandom), 3'($urandom_range(0, 7)));
      tick();
    end
    drive(1'b0, 8'h00, 8'h00, 3'd0);
    tick();
    chk("stream_pops", 64'(pops), 64'd100);

    // Reset with a full FIFO
    out_ready = 1'b0;
    drive(1'b1, 8'hFF, 8'h0F, 3'd6); tick(); tick();
    drive(1'b0, 8'h00, 8'h00, 3'd0);
    rst_n = 1'b0; tick();
    rst_n = 1'b1;
    chk("rst2_valid", 64'(out_valid), 64'd0);
    chk("rst2_ready", 64'(in_ready), 64'd1);
    chk("rst2_cnt", 64'(op_count), 64'd0);
    out_ready = 1'b1;
    tick(); tick();

    // Counter wrap: 17 accepted ops
    for (int i = 0; i < 17; i++) begin
      drive(1'b1, 8'($urandom), 8'($urandom), 3'($urandom_range(0, 7)));
      tick();
    end
    drive(1'b0, 8'h00, 8'h00, 3'd0);
    tick();
`ifdef LOGIC_UNIT_PIPE_STATS_EN
    chk("wrap_cnt4", 64'(op_count4), 64'd1);
`else
    chk("off_cnt4", 64'(op_count4), 64'd0);
`endif

    // Random valid/ready traffic
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), 3'($urandom_range(0, 7)));
      out_ready = 1'($urandom_range(0, 3) != 0);
      rst_n = ($urandom_range(0, 99) != 0);
      tick();
    end
    rst_n = 1'b1;
    drive(1'b0, 8'h00, 8'h00, 3'd0);
    out_ready = 1'b1;
    tick(); tick(); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/logic_unit_pipe.md
LOGIC_UNIT_PIPE -- requirements
Module: logic_unit_pipe

Interface
REQ-001 Parameter: WIDTH, default 8, operand and result width in bits (legal range 1..64).
REQ-002 Parameter: CNT_W, default 16, width of the transaction counter.
REQ-003 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-004 Port: rst_n  input  1  synchronous active-low reset, sampled on rising clk.
REQ-005 Port: in_valid  input  1  upstream offers an operation.
REQ-006 Port: in_ready  output  1  block accepts an operation this cycle.
REQ-007 Port: in_a  input  WIDTH  operand A.
REQ-008 Port: in_b  input  WIDTH  operand B, the per-bit mux select.
REQ-009 Port: in_op  input  3  operation code.
REQ-010 Port: out_valid  output  1  result available.
REQ-011 Port: out_ready  input  1  downstream takes the result.
REQ-012 Port: out_y  output  WIDTH  result.
REQ-013 Port: out_zero  output  1  out_y is all zeros.
REQ-014 Port: op_count  output  CNT_W  accepted-operation count.

Function
REQ-015 The block SHALL compute each result bit as a 2:1 mux selected by in_b[i] between functions of in_a[i]: AND 000 (b?a:0), OR 001 (b?1:a), NAND 010 (b?~a:1), NOR 011 (b?0:~a), XOR 100 (b?~a:a), XNOR 101 (b?a:~a), PASS_A 110 (a), NOT_A 111 (~a).
REQ-016 The block SHALL accept an operation on a rising edge where in_valid and in_ready are both 1; the result SHALL be registered together with the operation.
REQ-017 Results SHALL be buffered in a 2-entry in-order FIFO; in_ready SHALL equal (registered occupancy != 2) and SHALL NOT depend combinationally on out_ready.
REQ-018 Latency: an operation accepted at edge N SHALL appear on out_y with out_valid=1 after edge N when the FIFO was empty. Sustained throughput with out_ready=1 SHALL be one operation per cycle.
REQ-019 A result SHALL pop on a rising edge where out_valid and out_ready are both 1. out_y and out_zero SHALL hold stable while out_valid=1 and out_ready=0.
REQ-020 A simultaneous push and pop at occupancy 1 SHALL leave occupancy at 1, with the new result becoming the head. A pop at occupancy 2 SHALL not admit a push in the same cycle.
REQ-021 When out_valid=0, out_y SHALL be 0 and out_zero SHALL be 0.
REQ-022 in_a, in_b and in_op SHALL be ignored when in_valid=0 or in_ready=0.

Reset
REQ-023 While rst_n=0 at a rising edge, the block SHALL clear occupancy and both entries and set out_valid=0, out_y=0, out_zero=0, in_ready=1 and op_count=0.
REQ-024 A reset during operation SHALL discard all buffered results, and no stale result SHALL appear after reset.

Configuration
REQ-025 Macro LOGIC_UNIT_PIPE_STATS_EN: when defined, op_count SHALL increment by 1 per accepted operation, wrapping modulo 2^CNT_W. When undefined, op_count SHALL be tied to 0 and no counter flops SHALL be synthesised.

Structure
REQ-026 Package logic_unit_pkg SHALL hold the 3-bit op-code constants and enum (OP_AND..OP_NOT_A).
REQ-027 Sub-module gate_mux_cell, a combinational 1-bit mux-based gate taking a, b and op, SHALL be instantiated WIDTH times. The FIFO stays inline.

Verification (WIDTH=8)
REQ-028 Reset, then a=8'hF0, b=8'hCC, op=AND, out_ready=1 -> one cycle later out_y=8'hC0, out_zero=0. Repeat with XOR -> 8'h3C, and with NOR -> 8'h03.
REQ-029 a=8'h0F, b=8'hF0, op=AND -> out_y=8'h00, out_zero=1.
REQ-030 Hold out_ready=0 and offer 3 back-to-back ops -> in_ready=0 after 2 accepted. Raise out_ready -> results drain in order and the third op is accepted after the first pop.
REQ-031 Stream 100 ops with out_ready=1 -> 100 results in 100 consecutive cycles, and with the macro defined op_count=100.
REQ-032 Fill the FIFO to 2, pull rst_n low for one edge -> out_valid=0, in_ready=1, op_count=0, and no old result is ever emitted.
REQ-033 Stats check: CNT_W=4 with the macro defined, 17 accepted ops -> op_count=1. With the macro undefined -> op_count=0 throughout.
